// File: rtl/fifo_drain_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_drain_ctrl_if
//
// Groups the two data paths of the FIFO drain controller:
//   - FIFO read port : fifo_empty (FIFO -> ctrl), fifo_rden (ctrl -> FIFO),
//                      fifo_q (FIFO -> ctrl, valid the cycle after fifo_rden)
//   - Downstream port: out_valid / out_data (ctrl -> sink), out_ready (sink -> ctrl)
//
// Modports:
//   master : the drain controller side
//   slave  : the environment side (FIFO read port plus downstream sink)
// ---------------------------------------------------------------------------
interface fifo_drain_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_rden;
    logic [DATA_W-1:0] fifo_q;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_q,
        input  out_ready,
        output fifo_rden,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_q,
        output out_ready,
        input  fifo_rden,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_drain_ctrl
//
// Read-side controller for the register-emulated FIFO. A start request pops
// exactly i_len words from the FIFO read port, absorbs the FIFO's one-cycle
// read latency in a 2-entry in-order holding buffer, and hands every word to
// the downstream sink over a valid/ready handshake. o_done pulses for one
// cycle once the last word has been accepted downstream.
//
// Ports:
//   clk          : clock (FIFO read clock)
//   reset        : synchronous, active-high reset
//   i_start      : drain request, only looked at while idle
//   i_len        : number of words to drain, captured with i_start
//   o_busy       : high whenever the controller is not idle
//   o_done       : one-cycle completion pulse
//   o_words_sent : words accepted downstream in the current drain
//   bus          : FIFO read port and downstream handshake (master side)
// ---------------------------------------------------------------------------
module fifo_drain_ctrl #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_len,
    output logic               o_busy,
    output logic               o_done,
    output logic [LEN_W-1:0]   o_words_sent,
    fifo_drain_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;

    logic [LEN_W-1:0]  r_issueLeft;
    logic [LEN_W-1:0]  r_acceptLeft;
    logic [LEN_W-1:0]  r_wordsSent;
    logic              r_inflight;
    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;

    logic              w_rden;
    logic              w_pop;
    logic              w_acceptStart;
    logic [2:0]        w_occAfter;
    logic [LEN_W-1:0]  w_acceptLeftNext;

    // A downstream transfer happens whenever the buffer holds something and
    // the sink is ready; the oldest entry always sits in r_buf0.
    assign w_pop         = (r_occ != 2'd0) && bus.out_ready;
    assign w_acceptStart = (r_state == ST_IDLE) && i_start;

    // Occupancy the buffer will have once the word already in flight lands
    // and this cycle's pop leaves. A new read is only safe when that is below
    // two, which is what keeps the buffer from ever overflowing while still
    // allowing a read every cycle when the sink drains as fast as we fill.
    assign w_occAfter = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_acceptLeftNext = w_pop ? (r_acceptLeft - LEN_W'(1)) : r_acceptLeft;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and FIFO read-enable logic. FLUSH leaves on the cycle of the
    // final pop so that done lands exactly one cycle after it.
    always_comb begin
        w_stateNext = r_state;
        w_rden      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_stateNext = (i_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                w_rden = !bus.fifo_empty && (r_issueLeft != '0) && (w_occAfter < 3'd2);
                if (w_rden && (r_issueLeft == LEN_W'(1))) begin
                    w_stateNext = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_acceptLeftNext == '0) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Drain counters. A zero-length request also clears o_words_sent, since
    // that drain delivers no words.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issueLeft  <= '0;
            r_acceptLeft <= '0;
            r_wordsSent  <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_rden;
            if (w_acceptStart) begin
                r_issueLeft  <= i_len;
                r_acceptLeft <= i_len;
                r_wordsSent  <= '0;
            end else begin
                if (w_rden) begin
                    r_issueLeft <= r_issueLeft - LEN_W'(1);
                end
                if (w_pop) begin
                    r_acceptLeft <= w_acceptLeftNext;
                    r_wordsSent  <= r_wordsSent + LEN_W'(1);
                end
            end
        end
    end

    // Two-entry holding buffer. The word read last cycle arrives on fifo_q
    // while r_inflight is set and is appended behind whatever remains after
    // this cycle's pop. A word in flight across reset is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= bus.fifo_q;
                    end else begin
                        r_buf1 <= bus.fifo_q;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= bus.fifo_q;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= bus.fifo_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.fifo_rden = w_rden;
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_data  = r_buf0;

    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_words_sent = r_wordsSent;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_drain_ctrl
//
// Self-checking bench for fifo_drain_ctrl. A small FIFO model serves the read
// port with one cycle of latency; every word pushed into it is also queued as
// an expected downstream word, and the queue head is compared against
// out_data whenever out_valid is high, popping on each accepted transfer.
// ---------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  wordsSent;

    int                assertCount = 0;
    int                failCount   = 0;

    logic [DATA_W-1:0] fifoMem [0:63];
    int                wrPtr      = 0;
    int                rdPtr      = 0;
    int                rdenTotal  = 0;
    logic [DATA_W-1:0] expQ [$];

    int                tbOcc      = 0;
    logic              tbInflight = 1'b0;

    fifo_drain_ctrl_if #(.DATA_W(DATA_W)) bus ();

    fifo_drain_ctrl #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (start),
        .i_len        (len),
        .o_busy       (busy),
        .o_done       (done),
        .o_words_sent (wordsSent),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after fifo_rden.
    assign bus.fifo_empty = (wrPtr == rdPtr);

    always @(posedge clk) begin
        if (bus.fifo_rden) begin
            bus.fifo_q <= fifoMem[rdPtr % 64];
            rdPtr      <= rdPtr + 1;
            rdenTotal  <= rdenTotal + 1;
        end
    end

    // Reference occupancy: each read lands one cycle later, each accepted
    // transfer removes one word.
    always @(posedge clk) begin
        if (reset) begin
            tbOcc      <= 0;
            tbInflight <= 1'b0;
        end else begin
            tbInflight <= bus.fifo_rden;
            tbOcc      <= tbOcc + int'(tbInflight) - int'(bus.out_valid && bus.out_ready);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("occBound", 32'(tbOcc <= 2), 32'd1);
            checkOutput("validVsOcc", 32'(bus.out_valid), 32'(tbOcc != 0));
            if (bus.fifo_rden) begin
                checkOutput("rdenWhileEmpty", 32'(bus.fifo_empty), 32'd0);
            end
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("sbUnexpectedWord", 32'(expQ.size()), 32'd1);
                end else begin
                    checkOutput("sbData", 32'(bus.out_data), 32'(expQ[0]));
                    if (bus.out_ready) begin
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [LEN_W-1:0] l, input logic rdy);
        start         = s;
        len           = l;
        bus.out_ready = rdy;
    endtask

    task automatic pushWord(input logic [DATA_W-1:0] d);
        fifoMem[wrPtr % 64] = d;
        wrPtr               = wrPtr + 1;
        expQ.push_back(d);
    endtask

    task automatic checkAllZero(input string name);
        @(negedge clk);
        checkOutput({name, "_busy"},      32'(busy),          32'd0);
        checkOutput({name, "_done"},      32'(done),          32'd0);
        checkOutput({name, "_wordsSent"}, 32'(wordsSent),     32'd0);
        checkOutput({name, "_rden"},      32'(bus.fifo_rden), 32'd0);
        checkOutput({name, "_valid"},     32'(bus.out_valid), 32'd0);
        checkOutput({name, "_data"},      32'(bus.out_data),  32'd0);
    endtask

    // Cycle-by-cycle check of cycles 1..n after the start cycle.
    task automatic runCycles(input string name, input int n, input logic [15:0] eRden,
                             input logic [15:0] eValid, input logic [15:0] eDone, input logic [15:0] eBusy);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_rden_c%0d", name, c),  32'(bus.fifo_rden), 32'(eRden[c]));
            checkOutput($sformatf("%s_valid_c%0d", name, c), 32'(bus.out_valid), 32'(eValid[c]));
            checkOutput($sformatf("%s_done_c%0d", name, c),  32'(done),          32'(eDone[c]));
            checkOutput($sformatf("%s_busy_c%0d", name, c),  32'(busy),          32'(eBusy[c]));
            nextCycle();
        end
    endtask

    // Wait (bounded) for done, then check the drain totals and return to idle.
    task automatic finishDrain(input string name, input int expWords, input int expReads,
                               input int readBase, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            nextCycle();
        end
        checkOutput({name, "_doneSeen"},  32'(seen),                 32'd1);
        checkOutput({name, "_wordsSent"}, 32'(wordsSent),            32'(expWords));
        checkOutput({name, "_reads"},     32'(rdenTotal - readBase), 32'(expReads));
        nextCycle();
        @(negedge clk);
        checkOutput({name, "_busyAfter"}, 32'(busy),        32'd0);
        checkOutput({name, "_doneAfter"}, 32'(done),        32'd0);
        checkOutput({name, "_drained"},   32'(expQ.size()), 32'd0);
        nextCycle();
    endtask

    initial begin
        int readBase;

        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("reset");
        nextCycle();

        $display("[TB] basic drain");
        pushWord(8'hA1);
        pushWord(8'hB2);
        pushWord(8'hC3);
        readBase = rdenTotal;
        applyStimulus(1'b1, 4'd3, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b1);
        runCycles("basic", 7, 16'b0000_0000_0000_1110, 16'b0000_0000_0011_1000,
                  16'b0000_0000_0100_0000, 16'b0000_0000_0111_1110);
        @(negedge clk);
        checkOutput("basic_wordsSent", 32'(wordsSent),            32'd3);
        checkOutput("basic_reads",     32'(rdenTotal - readBase), 32'd3);
        checkOutput("basic_drained",   32'(expQ.size()),          32'd0);
        nextCycle();

        $display("[TB] zero length");
        readBase = rdenTotal;
        applyStimulus(1'b1, 4'd0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b1);
        runCycles("zero", 3, 16'b0000, 16'b0000, 16'b0010, 16'b0010);
        checkOutput("zero_reads", 32'(rdenTotal - readBase), 32'd0);

        $display("[TB] backpressure");
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        pushWord(8'h44);
        readBase = rdenTotal;
        applyStimulus(1'b1, 4'd4, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        runCycles("bp", 9, 16'b0000_0000_0000_0110, 16'b0000_0011_1111_1000,
                  16'b0000_0000_0000_0000, 16'b0000_0011_1111_1110);
        checkOutput("bp_readAhead", 32'(rdenTotal - readBase), 32'd2);
        applyStimulus(1'b0, 4'd0, 1'b1);
        finishDrain("bp", 4, 4, readBase, 20);

        $display("[TB] empty stall");
        readBase = rdenTotal;
        applyStimulus(1'b1, 4'd2, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b1);
        runCycles("stall", 7, 16'b0000, 16'b0000, 16'b0000, 16'b0000_0000_1111_1110);
        checkOutput("stall_noReads", 32'(rdenTotal - readBase), 32'd0);
        pushWord(8'h5A);
        nextCycle();
        pushWord(8'h6B);
        finishDrain("stall", 2, 2, readBase, 20);

        $display("[TB] ignored restart");
        pushWord(8'h71);
        pushWord(8'h72);
        readBase = rdenTotal;
        applyStimulus(1'b1, 4'd2, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 4'd5, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b1);
        finishDrain("restart", 2, 2, readBase, 20);

        $display("[TB] mid-drain reset");
        pushWord(8'h81);
        pushWord(8'h82);
        pushWord(8'h83);
        pushWord(8'h84);
        pushWord(8'h85);
        applyStimulus(1'b1, 4'd5, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        // 0x81 and 0x82 were read ahead and are lost with the reset.
        expQ.delete();
        checkAllZero("midReset");
        nextCycle();
        expQ.push_back(8'h83);
        readBase = rdenTotal;
        applyStimulus(1'b1, 4'd1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 4'd0, 1'b1);
        finishDrain("afterReset", 1, 1, readBase, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller for the register-emulated FIFO. On a `start` request it pops exactly `len` words from the FIFO read port, absorbing the FIFO's one-cycle read latency in a 2-entry holding buffer. It presents each word downstream on a valid/ready handshake and pulses `done` when the last word has been accepted. It runs entirely in the FIFO's read-clock domain and is the consumer counterpart to the FIFO's write-side producers.

## Interface
- `DATA_W`, default 8: FIFO word width.
- `LEN_W`, default 4: width of the `len` and `words_sent` fields.
- `clk`, input, 1: clock, connected to the FIFO read clock.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request a drain of `len` words. Sampled only in IDLE.
- `len`, input, `LEN_W`: number of words to drain. Sampled with `start`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse on completion.
- `words_sent`, output, `LEN_W`: count of words accepted downstream in the current drain.
- `fifo_empty`, input, 1: FIFO Empty flag.
- `fifo_rden`, output, 1: FIFO read enable, one pop per high cycle.
- `fifo_q`, input, `DATA_W`: FIFO read data, valid the cycle after `fifo_rden`.
- `out_valid`, output, 1: downstream data valid.
- `out_data`, output, `DATA_W`: downstream data.
- `out_ready`, input, 1: downstream ready.

## Operation
- **States.** IDLE, READ, FLUSH, DONE.
- **IDLE.**
  - On `start` with `len`≠0: latch `issue_left`=`len` and `accept_left`=`len`, clear `words_sent`, go to READ.
  - On `start` with `len`=0: go to DONE directly.
  - `start` in any other state is ignored.
- **READ.**
  - `fifo_rden` = `!fifo_empty` && `issue_left`≠0 && (`occ` + `inflight` − `pop`) < 2.
  - `occ` is the buffer occupancy (0–2).
  - `inflight` is `fifo_rden` registered from the previous cycle.
  - `pop` = `out_valid` && `out_ready`.
  - Each `fifo_rden` decrements `issue_left`. When `issue_left` reaches 0, go to FLUSH.
- **FLUSH.** No reads are issued. Go to DONE when `accept_left`=0.
- **DONE.** Assert `done` for one cycle, then go to IDLE. `words_sent` holds its value until the next accepted `start`.
- **Holding buffer.**
  - 2-entry, in-order.
  - When `inflight`=1, `fifo_q` is written into the buffer at the end of that cycle.
  - `out_valid` = (`occ`≠0). `out_data` is the oldest entry.
  - Each `pop` decrements `accept_left`, increments `words_sent` and removes the oldest entry.
  - A simultaneous write and `pop` leaves `occ` unchanged.
- **Output stability.** While `out_valid` && !`out_ready`, `out_data` and `out_valid` hold stable.
- **Overflow guard.** The issue condition guarantees `occ` never exceeds 2. A violation is an assertion failure in the bench.
- **Arithmetic.** All counters are `LEN_W` bits and never wrap in legal operation, because the counts are bounded by `len`.
- **Empty FIFO.** While `fifo_empty`=1, READ stalls indefinitely with no timeout. `fifo_rden` is never asserted while `fifo_empty`=1.
- **Reset.**
  - Return to IDLE; clear the buffer, `occ`, `inflight` and all counters.
  - Any word in flight from the FIFO is discarded, not replayed.
  - All outputs are 0 after reset: `busy`, `done`, `words_sent`, `fifo_rden`, `out_valid`, `out_data`.

## Timing
- Cycle 0: `start` sampled. Cycle 1: state READ, first `fifo_rden` possible.
- Latency: `fifo_q` is valid in cycle 2, and `out_valid` rises in cycle 3. First-word latency is 3 cycles from `start`.
- Throughput: with `out_ready` held high and the FIFO non-empty, `fifo_rden` is high every cycle. This relies on the combinational `out_ready` → `fifo_rden` path. Sustained rate is 1 word/cycle.
- Completion: `done` pulses 1 cycle after the final `pop`. `busy` falls in the cycle after `done`.
- `len`=0: `done` pulses in cycle 1 and no `fifo_rden` is asserted.
- Backpressure: with `out_ready` low, at most 2 words are read ahead. Then `fifo_rden` stays low.

## Test plan
- **Basic drain.** FIFO holds A1,B2,C3. `start`, `len`=3, `out_ready`=1.
  - Expect `fifo_rden` in cycles 1–3 and `out_data` A1,B2,C3 in cycles 3–5.
  - Expect `done` in cycle 6 and `words_sent`=3.
- **Zero length.** `start`, `len`=0.
  - Expect `done` in cycle 1, no `fifo_rden`, `busy` high for cycle 1 only.
- **Backpressure.** `len`=4, `out_ready`=0 until cycle 10.
  - Expect exactly 2 `fifo_rden` pulses, `out_data` stable while stalled.
  - After release, 4 words delivered in order and `done` follows.
- **Empty stall.** `len`=2, FIFO empty until cycle 8, then one word pushed per cycle.
  - Expect no `fifo_rden` before `fifo_empty` falls.
  - Expect correct data, and `done` after the 2nd pop.
- **Ignored restart.** `start` pulsed during READ with a different `len`.
  - Expect no effect; the drain completes with the original `len`.
- **Mid-drain reset.** `len`=5, assert `reset` in cycle 4.
  - Expect all outputs 0 the next cycle and state IDLE.
  - A new `start` with `len`=1 then drains exactly one word.
